mem_arbiter: RTL and testbench

- Shares the single-port program/data memory between two requesters: port 0 is the CPU, port 1 is the secondary master (debug loader / display dump engine).
- Sits between the requesters and the memory: it drives the memory's we/addr/data and returns the memory's registered read output.
- Round-robin arbitration with a bounded burst tenure, so neither port can starve the other.

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/rr_pick2.sv | 19 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic any
);

  always_comb begin
    any = req0 | req1;
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a single-port memory between the CPU (port 0)
// and a secondary master (port 1), with bounded burst tenure.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_out
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;

  logic            idle_win, idle_any;
  logic            hand_req0, hand_req1;
  logic            hand_win, hand_any;
  logic            owner_g1, owner_req;

  rr_pick2 u_idle_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last_q),
    .winner (idle_win),
    .any    (idle_any)
  );

  // Only the non-owner's request competes for a handover.
  assign hand_req0 = (state_q == ST_G1) & req0;
  assign hand_req1 = (state_q == ST_G0) & req1;

  rr_pick2 u_hand_pick (
    .req0   (hand_req0),
    .req1   (hand_req1),
    .last   (last_q),
    .winner (hand_win),
    .any    (hand_any)
  );

  always_comb begin
    owner_g1  = (state_q == ST_G1);
    owner_req = owner_g1 ? req1 : req0;
    gnt0      = (state_q == ST_G0) & req0;
    gnt1      = (state_q == ST_G1) & req1;
    mem_addr  = owner_g1 ? addr1 : addr0;
    mem_data  = owner_g1 ? wdata1 : wdata0;
    mem_we    = (gnt0 & we0) | (gnt1 & we1);
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;

    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;

    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (idle_any) begin
          state_d = idle_win ? ST_G1 : ST_G0;
        end
      end
      ST_G0, ST_G1: begin
        // Leave when the owner is done, or when its tenure is used up and the
        // other port is waiting; the current cycle's access still completes.
        if (!owner_req || (hand_any && (burst_q == BURST_LAST))) begin
          last_d  = owner_g1;
          burst_d = '0;
          if (hand_any) begin
            state_d = hand_win ? ST_G1 : ST_G0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (burst_q != BURST_LAST) begin
          burst_d = burst_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      burst_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = mem_out;
  assign rdata1  = mem_out;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand sequences
// and randomized traffic compared against a tenure-level reference model.
module tb_mem_arbiter;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_data, mem_out;
  logic [AW-1:0] mem_addr;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 5) ? 16'h1234 : 16'h1000 + DW'(i);
  endfunction

  // Single-port memory with registered read output.
  logic [DW-1:0] mem [64];
  logic          mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      mem_loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_data;
      mem_out <= mem[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner port (0 none, 1 port0, 2 port1), grants taken in
  // the current tenure, and which port held the memory most recently.
  int            m_owner, m_last, m_cnt;
  logic          m_rv [2];
  logic [DW-1:0] m_rd [2];
  logic [DW-1:0] shadow [64];
  logic          e_g0, e_g1;

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_cnt = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0;
    e_g0 = 1'b0; e_g1 = 1'b0;
  endtask

  task automatic model_check();
    logic ewe;
    e_g0 = (m_owner == 1) && req0;
    e_g1 = (m_owner == 2) && req1;
    ewe  = (e_g0 && we0) || (e_g1 && we1);
    chk("gnt0", gnt0, e_g0);
    chk("gnt1", gnt1, e_g1);
    chk("mem_we", mem_we, ewe);
    if (e_g0) chk("mem_addr_p0", mem_addr, addr0);
    if (e_g1) chk("mem_addr_p1", mem_addr, addr1);
    if (ewe) chk("mem_data", mem_data, e_g0 ? wdata0 : wdata1);
    chk("rvalid0", rvalid0, m_rv[0]);
    chk("rvalid1", rvalid1, m_rv[1]);
    if (m_rv[0]) chk("rdata0", rdata0, m_rd[0]);
    if (m_rv[1]) chk("rdata1", rdata1, m_rd[1]);
  endtask

  task automatic model_update();
    int   me;
    logic mine, other;
    m_rv[0] = e_g0 && !we0; m_rd[0] = shadow[addr0];
    m_rv[1] = e_g1 && !we1; m_rd[1] = shadow[addr1];
    if (e_g0 && we0) shadow[addr0] = wdata0;
    if (e_g1 && we1) shadow[addr1] = wdata1;
    if (m_owner == 0) begin
      m_cnt = 0;
      if (req0 && req1) m_owner = (m_last == 1) ? 1 : 2;
      else if (req0) m_owner = 1;
      else if (req1) m_owner = 2;
    end else begin
      me    = m_owner - 1;
      mine  = (me == 1) ? req1 : req0;
      other = (me == 1) ? req0 : req1;
      if (!mine) begin
        m_last = me; m_cnt = 0;
        m_owner = other ? 3 - m_owner : 0;
      end else begin
        m_cnt++;
        if (other && m_cnt >= MB) begin
          m_last = me; m_cnt = 0; m_owner = 3 - m_owner;
        end
      end
    end
  endtask

  task automatic settle_check();
    #3;
    model_check();
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input logic granted, input int busy, inout logic r, inout logic w,
                     inout logic [AW-1:0] a, inout logic [DW-1:0] d);
    if (r && !granted) begin
      if ($urandom_range(15) == 0) r = 1'b0;
    end else begin
      r = ($urandom_range(99) < busy);
      w = ($urandom_range(2) == 0);
      a = AW'($urandom_range(7));
      if ($urandom_range(3) == 0) a = AW'($urandom_range(63));
      d = DW'($urandom);
    end
  endtask

  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic eg0, eg1, ewe; logic [AW-1:0] eaddr; logic [DW-1:0] edata;
    logic erv0, erv1; logic [DW-1:0] erd;
  } vec_t;

  function automatic vec_t mk(bit r0, bit w0, int a0, int d0, bit r1, bit w1, int a1, int d1,
                              bit eg0, bit eg1, bit ewe, int eaddr, int edata,
                              bit erv0, bit erv1, int erd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = DW'(d0);
    v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = DW'(d1);
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.eaddr = AW'(eaddr); v.edata = DW'(edata);
    v.erv0 = erv0; v.erv1 = erv1; v.erd = DW'(erd);
    return v;
  endfunction

  vec_t vec [19];
  logic [8:0] early_g0 = 9'b1_0000_0110;
  logic [8:0] early_g1 = 9'b0_1111_0000;

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
    // Read mem[5], port 1 writes 10, port 0 reads it back, then contention.
    vec[0]  = mk(1,0,5,0,      0,0,0,0,       0,0,0,0,0,       0,0,0);
    vec[1]  = mk(1,0,5,0,      0,0,0,0,       1,0,0,5,0,       0,0,0);
    vec[2]  = mk(0,0,5,0,      0,0,0,0,       0,0,0,0,0,       1,0,16'h1234);
    vec[3]  = mk(0,0,5,0,      1,1,10,16'hBEEF, 0,0,0,0,0,     0,0,0);
    vec[4]  = mk(0,0,5,0,      1,1,10,16'hBEEF, 0,1,1,10,16'hBEEF, 0,0,0);
    vec[5]  = mk(1,0,10,0,     0,1,10,16'hBEEF, 0,0,0,0,0,     0,0,0);
    vec[6]  = mk(1,0,10,0,     0,0,0,0,       1,0,0,10,0,      0,0,0);
    vec[7]  = mk(0,0,10,0,     0,0,0,0,       0,0,0,0,0,       1,0,16'hBEEF);
    vec[8]  = mk(1,0,1,0,      1,0,2,0,       0,0,0,0,0,       0,0,0);
    vec[9]  = mk(1,0,1,0,      1,0,2,0,       0,1,0,2,0,       0,0,0);
    for (int i = 10; i <= 12; i++)
      vec[i] = mk(1,0,1,0,     1,0,2,0,       0,1,0,2,0,       0,1,16'h1002);
    vec[13] = mk(1,0,1,0,      1,0,2,0,       1,0,0,1,0,       0,1,16'h1002);
    for (int i = 14; i <= 16; i++)
      vec[i] = mk(1,0,1,0,     1,0,2,0,       1,0,0,1,0,       1,0,16'h1001);
    vec[17] = mk(1,0,1,0,      1,0,2,0,       0,1,0,2,0,       1,0,16'h1001);
    vec[18] = mk(0,0,1,0,      0,0,2,0,       0,0,0,0,0,       0,1,16'h1002);

    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid", {rvalid0, rvalid1}, 0);
    chk("rst_mem_we", mem_we, 0);
    rst_n = 1'b1;
    settle_check();
    chk("rst_rel_idle", {gnt0, gnt1}, 2'b00);
    advance();
    settle_check();
    chk("rst_rel_gnt0", gnt0, 1);
    chk("rst_rel_gnt1", gnt1, 0);
    advance();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) begin settle_check(); advance(); end

    for (int i = 0; i < 19; i++) begin
      req0 = vec[i].r0; we0 = vec[i].w0; addr0 = vec[i].a0; wdata0 = vec[i].d0;
      req1 = vec[i].r1; we1 = vec[i].w1; addr1 = vec[i].a1; wdata1 = vec[i].d1;
      settle_check();
      chk($sformatf("vec%0d_gnt", i), {gnt0, gnt1}, {vec[i].eg0, vec[i].eg1});
      chk($sformatf("vec%0d_we", i), mem_we, vec[i].ewe);
      if (vec[i].eg0 || vec[i].eg1) chk($sformatf("vec%0d_addr", i), mem_addr, vec[i].eaddr);
      if (vec[i].ewe) chk($sformatf("vec%0d_data", i), mem_data, vec[i].edata);
      chk($sformatf("vec%0d_rvalid", i), {rvalid0, rvalid1}, {vec[i].erv0, vec[i].erv1});
      if (vec[i].erv0) chk($sformatf("vec%0d_rdata0", i), rdata0, vec[i].erd);
      if (vec[i].erv1) chk($sformatf("vec%0d_rdata1", i), rdata1, vec[i].erd);
      advance();
    end

    // Port 0 releases after two accesses; port 1 then gets a fresh full tenure.
    we0 = 1'b0; we1 = 1'b0; addr0 = 6'd3; addr1 = 6'd4;
    for (int i = 0; i < 9; i++) begin
      req0 = (i != 3); req1 = 1'b1;
      settle_check();
      chk($sformatf("early%0d_gnt0", i), gnt0, early_g0[i]);
      chk($sformatf("early%0d_gnt1", i), gnt1, early_g1[i]);
      advance();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) begin settle_check(); advance(); end

    // Reset lands while a write is issued and the previous read is returning.
    req0 = 1'b1; we0 = 1'b0; addr0 = 6'd5;
    settle_check(); advance();
    settle_check(); advance();
    we0 = 1'b1; addr0 = 6'd7; wdata0 = 16'hCAFE;
    settle_check();
    chk("midrst_pre_we", mem_we, 1);
    chk("midrst_pre_rvalid0", rvalid0, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", {gnt0, gnt1}, 2'b00);
    chk("midrst_rvalid0", rvalid0, 0);
    chk("midrst_mem_we", mem_we, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    settle_check();
    chk("midrst_idle", {gnt0, gnt1}, 2'b00);
    advance();
    settle_check();
    chk("midrst_p0_first", {gnt0, gnt1}, 2'b10);
    advance();

    for (int i = 0; i < 800; i++) begin
      gen(e_g0, ((i / 200) % 2 == 1) ? 90 : 50, req0, we0, addr0, wdata0);
      gen(e_g1, 70, req1, we1, addr1, wdata1);
      settle_check();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
